// File: rtl/register_file_if.sv
// Register-file access bus: write port plus two combinational read ports.
// The master drives the addresses and write data. The slave (the register file) returns the read data.
interface register_file_if;
    logic        RegWrite;
    logic        UART_write_enable;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rw;
    logic [31:0] write_data;
    logic [31:0] op1_sub;
    logic [31:0] op2_sub;

    modport master (
        output RegWrite, UART_write_enable, rs, rt, rw, write_data,
        input  op1_sub, op2_sub
    );

    modport slave (
        input  RegWrite, UART_write_enable, rs, rt, rw, write_data,
        output op1_sub, op2_sub
    );
endinterface

// File: rtl/register_file.sv
// 32x32 register file: entry 0 hardwired to zero, two combinational read ports, one write port.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module register_file (
    input  logic            clk,
    input  logic            reset,
    register_file_if.slave  bus
);
    logic [31:0][31:0] mem_q, mem_d;
    logic              wr_en;
    logic              wr_fire;

    assign wr_en   = bus.RegWrite | bus.UART_write_enable;
    // Writes to entry 0 are dropped, so mem_q[0] stays at its reset value of zero.
    assign wr_fire = wr_en & reset & (bus.rw != 5'd0);

    always_comb begin
        mem_d = mem_q;
        if (wr_fire) mem_d[bus.rw] = bus.write_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mem_q <= '0;
        else        mem_q <= mem_d;
    end

    always_comb begin
        bus.op1_sub = (bus.rs == 5'd0) ? 32'h0 : mem_q[bus.rs];
        bus.op2_sub = (bus.rt == 5'd0) ? 32'h0 : mem_q[bus.rt];
`ifdef REGFILE_BYPASS_EN
        // wr_fire already excludes rw=0 and reset, so address 0 and reset reads remain zero.
        if (wr_fire && (bus.rw == bus.rs)) bus.op1_sub = bus.write_data;
        if (wr_fire && (bus.rw == bus.rt)) bus.op2_sub = bus.write_data;
`endif
    end
endmodule

// File: tb/tb_register_file.sv
// Randomized and directed check of register_file against an array-based reference model.
// Expected reads follow the forwarding rule when REGFILE_BYPASS_EN is defined.
module tb_register_file;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;
    logic [31:0] model [32];

    register_file_if rf_if ();

    register_file dut (
        .clk   (clk),
        .reset (reset),
        .bus   (rf_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // The expected read value is derived from the current bench inputs and the model contents.
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0 || !reset) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if ((rf_if.RegWrite || rf_if.UART_write_enable) && rf_if.rw == a) return rf_if.write_data;
`endif
        return model[a];
    endfunction

    task automatic check_ports(input string tag);
        chk({tag, "_op1"}, rf_if.op1_sub, exp_rd(rf_if.rs));
        chk({tag, "_op2"}, rf_if.op2_sub, exp_rd(rf_if.rt));
    endtask

    task automatic step(input logic we, input logic uart, input logic [4:0] a_rw,
                        input logic [31:0] wd, input logic [4:0] a_rs, input logic [4:0] a_rt);
        @(negedge clk);
        rf_if.RegWrite          = we;
        rf_if.UART_write_enable = uart;
        rf_if.rw                = a_rw;
        rf_if.write_data        = wd;
        rf_if.rs                = a_rs;
        rf_if.rt                = a_rt;
        #1 check_ports("pre");
        @(posedge clk);
        if (reset && (we || uart) && a_rw != 5'd0) model[a_rw] = wd;
        #1 check_ports("post");
    endtask

    // Asserts reset between clock edges and checks that every address reads zero immediately.
    // The enable stays high throughout, so the write is ignored while reset is low.
    task automatic reset_pulse(input logic [4:0] probe);
        @(negedge clk);
        rf_if.RegWrite   = 1'b1;
        rf_if.rw         = probe;
        rf_if.write_data = 32'hA5A5A5A5;
        rf_if.rs         = probe;
        rf_if.rt         = probe;
        #2 reset = 1'b0;
        #1 chk("rst_immediate", rf_if.op1_sub, 32'h0);
        for (int i = 0; i < 32; i++) begin
            rf_if.rs = 5'(i);
            rf_if.rt = 5'(31 - i);
            #1;
            chk("rst_sweep_op1", rf_if.op1_sub, 32'h0);
            chk("rst_sweep_op2", rf_if.op2_sub, 32'h0);
        end
        foreach (model[i]) model[i] = 32'h0;
        rf_if.RegWrite = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        foreach (model[i]) model[i] = 32'h0;
        rf_if.RegWrite          = 1'b0;
        rf_if.UART_write_enable = 1'b0;
        rf_if.rs                = 5'd0;
        rf_if.rt                = 5'd0;
        rf_if.rw                = 5'd0;
        rf_if.write_data        = 32'h0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            rf_if.rs = 5'(i);
            #1 chk("init_reset", rf_if.op1_sub, 32'h0);
        end
        @(negedge clk);
        reset = 1'b1;

        // Basic write followed by a readback.
        step(1'b1, 1'b0, 5'd1, 32'h10101010, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd1);
        chk("basic_rd", rf_if.op1_sub, 32'h10101010);
        // A write and a read happen in parallel.
        step(1'b1, 1'b0, 5'd2, 32'h10101010, 5'd1, 5'd2);
        chk("parallel_op1", rf_if.op1_sub, 32'h10101010);
        chk("parallel_op2", rf_if.op2_sub, 32'h10101010);
        // A disabled write leaves the entry unchanged. A UART write then lands.
        repeat (3) step(1'b0, 1'b0, 5'd3, 32'hDEADBEEF, 5'd3, 5'd4);
        chk("disabled_wr", rf_if.op1_sub, 32'h0);
        step(1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd3);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd1);
        chk("uart_wr", rf_if.op1_sub, 32'hDEADBEEF);
        // Register 0 is hardwired to zero, including when both enables are set.
        step(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        step(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        chk("r0_op1", rf_if.op1_sub, 32'h0);
        chk("r0_op2", rf_if.op2_sub, 32'h0);
        // Both enables asserted together cause a single write.
        step(1'b1, 1'b1, 5'd7, 32'hCAFEF00D, 5'd7, 5'd7);
        chk("both_en", rf_if.op2_sub, 32'hCAFEF00D);

        for (int n = 0; n < 400; n++) begin
            logic [1:0] en;
            en = 2'($urandom_range(0, 3));
            step(en[0], en[1], 5'($urandom), $urandom,
                 (n % 8 == 0) ? 5'd0 : 5'($urandom), 5'($urandom));
        end

        // Reset in the middle of operation clears entry 5 without waiting for a clock edge.
        step(1'b1, 1'b0, 5'd5, 32'h12345678, 5'd5, 5'd5);
        chk("mid_wr", rf_if.op1_sub, 32'h12345678);
        reset_pulse(5'd5);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd9);
        chk("after_rst", rf_if.op1_sub, 32'h0);

        for (int n = 0; n < 100; n++)
            step($urandom_range(0, 1) == 1, 1'b0, 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
        reset_pulse(5'($urandom));
        step(1'b0, 1'b1, 5'd31, 32'h0BADF00D, 5'd31, 5'd30);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd31);
        chk("post_rst_wr", rf_if.op1_sub, 32'h0BADF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
